// File: rtl/pipe_ctrl_chain.sv
// Parametrised control-word pipeline with per-stage valid bits,
// bubble insertion behind stalls and deferred flush capture during global holds.
module pipe_ctrl_chain #(
  parameter int WIDTH = 32,
  parameter int STAGES = 3,
  parameter logic [WIDTH-1:0] FLUSH_VAL = {WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        din,
  input  logic                    din_valid,
  input  logic [STAGES-1:0]       stall,
  input  logic [STAGES-1:0]       flush,
  input  logic                    inst_stall_F,
  input  logic                    data_stall_M,
  output logic [STAGES*WIDTH-1:0] dout,
  output logic [STAGES-1:0]       valid,
  output logic [STAGES-1:0]       flush_pend
);

  logic [WIDTH-1:0]  r    [STAGES];
  logic [WIDTH-1:0]  up_d [STAGES];
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] p;
  logic [STAGES-1:0] up_v;
  logic [STAGES-1:0] bub;
  logic              hold;

  assign hold = inst_stall_F | data_stall_M;

  // Stage 0 is fed from decode and never takes a bubble
  assign up_d[0] = din;
  assign up_v[0] = din_valid;
  assign bub[0]  = 1'b0;

  genvar k;
  generate
    for (k = 1; k < STAGES; k++) begin : g_up
      assign up_d[k] = r[k-1];
      assign up_v[k] = v[k-1];
      assign bub[k]  = stall[k-1];
    end
    for (k = 0; k < STAGES; k++) begin : g_out
      assign dout[k*WIDTH +: WIDTH] = r[k];
    end
  endgenerate

  assign valid      = v;
  assign flush_pend = p;

  // Per-stage update: hold > flush > stall > bubble > load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r[i] <= FLUSH_VAL;
        v[i] <= 1'b0;
        p[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (hold) begin
          p[i] <= p[i] | flush[i];
        end else if (flush[i] | p[i]) begin
          r[i] <= FLUSH_VAL;
          v[i] <= 1'b0;
          p[i] <= 1'b0;
        end else if (stall[i]) begin
          r[i] <= r[i];
        end else if (bub[i]) begin
          r[i] <= FLUSH_VAL;
          v[i] <= 1'b0;
        end else begin
          r[i] <= up_d[i];
          v[i] <= up_v[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed table-driven bench for pipe_ctrl_chain
// (WIDTH=8, STAGES=3, FLUSH_VAL=0).
module tb_pipe_ctrl_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din;
  logic        din_valid;
  logic [2:0]  stall;
  logic [2:0]  flush;
  logic        inst_stall_F;
  logic        data_stall_M;
  logic [23:0] dout;
  logic [2:0]  valid;
  logic [2:0]  flush_pend;

  int n_vec = 0;
  int n_bad = 0;

  pipe_ctrl_chain #(
    .WIDTH(8), .STAGES(3), .FLUSH_VAL(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .stall(stall), .flush(flush),
    .inst_stall_F(inst_stall_F), .data_stall_M(data_stall_M),
    .dout(dout), .valid(valid), .flush_pend(flush_pend)
  );

  always #5 clk = ~clk;

  // Stalls must be contiguous from the front of the pipe
  always @(posedge clk) begin
    if (!rst) begin
      assert (((stall + 3'd1) & stall) == 3'd0)
        else $error("illegal stall pattern %b", stall);
    end
  end

  typedef struct {
    logic [7:0]  din;
    logic        dv;
    logic [2:0]  stall;
    logic [2:0]  flush;
    logic        ist;
    logic        dst;
    logic [23:0] dout;
    logic [2:0]  valid;
    logic [2:0]  pend;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] d, input logic dv,
                     input logic [2:0] st, input logic [2:0] fl,
                     input logic is, input logic ds,
                     input logic [23:0] ed, input logic [2:0] ev,
                     input logic [2:0] ep);
    vec_t t;
    t.din = d; t.dv = dv; t.stall = st; t.flush = fl;
    t.ist = is; t.dst = ds;
    t.dout = ed; t.valid = ev; t.pend = ep;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [23:0] ed,
                       input logic [2:0] ev, input logic [2:0] ep);
    n_vec++;
    if (dout !== ed || valid !== ev || flush_pend !== ep) begin
      n_bad++;
      $display("FAIL %s: dout=%h valid=%b pend=%b, want dout=%h valid=%b pend=%b",
               name, dout, valid, flush_pend, ed, ev, ep);
    end
  endtask

  task automatic drive_idle();
    din = 8'h00; din_valid = 1'b0; stall = 3'b000; flush = 3'b000;
    inst_stall_F = 1'b0; data_stall_M = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();

    //  din   dv st    fl     is ds  dout {s2,s1,s0} valid pend
    // free flow
    add(8'h11,1,3'b000,3'b000,0,0, 24'h000011, 3'b001, 3'b000);
    add(8'h22,1,3'b000,3'b000,0,0, 24'h001122, 3'b011, 3'b000);
    add(8'h33,1,3'b000,3'b000,0,0, 24'h112233, 3'b111, 3'b000);
    // bubble behind stalled stage 1
    add(8'h44,1,3'b011,3'b000,0,0, 24'h002233, 3'b011, 3'b000);
    add(8'h44,1,3'b000,3'b000,0,0, 24'h223344, 3'b111, 3'b000);
    // deferred flush of stage 1 under D-cache hold
    add(8'h55,1,3'b000,3'b000,0,1, 24'h223344, 3'b111, 3'b000);
    add(8'h55,1,3'b000,3'b010,0,1, 24'h223344, 3'b111, 3'b010);
    add(8'h55,1,3'b000,3'b000,0,1, 24'h223344, 3'b111, 3'b010);
    add(8'h55,1,3'b000,3'b000,0,1, 24'h223344, 3'b111, 3'b010);
    add(8'h55,1,3'b000,3'b000,0,0, 24'h330055, 3'b101, 3'b000);
    // flush beats stall, stays empty while stall persists
    add(8'h66,1,3'b001,3'b001,0,0, 24'h000000, 3'b000, 3'b000);
    add(8'h66,1,3'b000,3'b000,0,0, 24'h000066, 3'b001, 3'b000);
    add(8'h77,1,3'b001,3'b001,0,0, 24'h000000, 3'b000, 3'b000);
    add(8'h88,1,3'b001,3'b000,0,0, 24'h000000, 3'b000, 3'b000);
    // din_valid=0 still loads its contents
    add(8'h77,1,3'b000,3'b000,0,0, 24'h000077, 3'b001, 3'b000);
    add(8'h88,0,3'b000,3'b000,0,0, 24'h007788, 3'b010, 3'b000);
    add(8'h99,1,3'b000,3'b000,0,0, 24'h778899, 3'b101, 3'b000);
    // repeated flush pulses under I-cache hold collapse
    add(8'hAA,1,3'b000,3'b001,1,0, 24'h778899, 3'b101, 3'b001);
    add(8'hAA,1,3'b000,3'b000,1,0, 24'h778899, 3'b101, 3'b001);
    add(8'hAA,1,3'b000,3'b001,1,0, 24'h778899, 3'b101, 3'b001);
    add(8'hAA,1,3'b000,3'b001,1,0, 24'h778899, 3'b101, 3'b001);
    add(8'hAA,1,3'b000,3'b000,0,0, 24'h889900, 3'b010, 3'b000);
    add(8'hBB,1,3'b000,3'b000,0,0, 24'h9900BB, 3'b101, 3'b000);
    // full stall, then flush of last stage
    add(8'hCC,1,3'b111,3'b000,0,0, 24'h9900BB, 3'b101, 3'b000);
    add(8'hCC,1,3'b000,3'b100,0,0, 24'h00BBCC, 3'b011, 3'b000);
    // stall bits ignored during hold
    add(8'hDD,1,3'b111,3'b000,1,0, 24'h00BBCC, 3'b011, 3'b000);
    add(8'hDD,1,3'b000,3'b000,0,0, 24'hBBCCDD, 3'b111, 3'b000);

    // reset state
    repeat (2) @(posedge clk);
    #1 check("reset", 24'h0, 3'b000, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      din = tbl[i].din; din_valid = tbl[i].dv;
      stall = tbl[i].stall; flush = tbl[i].flush;
      inst_stall_F = tbl[i].ist; data_stall_M = tbl[i].dst;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), tbl[i].dout, tbl[i].valid,
               tbl[i].pend);
    end

    // async reset in the middle of a hold with a pending flush
    @(negedge clk);
    drive_idle();
    inst_stall_F = 1'b1; flush = 3'b100;
    @(posedge clk);
    #1 check("hold_pend", 24'hBBCCDD, 3'b111, 3'b100);
    #2 flush = 3'b000;
    rst = 1'b1;
    #1 check("async_rst", 24'h0, 3'b000, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    inst_stall_F = 1'b0;
    din = 8'hEE; din_valid = 1'b1;
    @(posedge clk);
    #1 check("post_rst", 24'h0000EE, 3'b001, 3'b000);
    @(negedge clk);
    din = 8'hF0;
    @(posedge clk);
    #1 check("post_rst2", 24'h00EEF0, 3'b011, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
